ddr3_line_ctrl: RTL

Line-granular adapter between the DDR3 cache controller and the Xilinx MIG user (app) interface. It receives one 256-bit cache-line read or write request on a level-held request/ack handshake. It splits each request into two 128-bit MIG bursts, assembles read data back into a full line, and returns a single-cycle ack. After reset it also emits one ack once MIG calibration completes, which releases the cache controller from its init state.

---
 rtl/ddr3_pkg.sv | 29 ++
 rtl/ddr3_line_asm.sv | 40 ++++
 rtl/ddr3_line_ctrl.sv | 135 +++++++++++++
 3 files changed

// File: rtl/ddr3_pkg.sv
// Shared constants for the DDR3 line adapter: FSM state codes, MIG command codes
// and line/beat widths.
package ddr3_pkg;

  localparam int LINE_W     = 256;
  localparam int BEAT_W     = 128;
  localparam int LINE_IDX_W = 24;

  localparam logic [2:0] APP_CMD_WR = 3'b000;
  localparam logic [2:0] APP_CMD_RD = 3'b001;

  localparam logic [3:0] ST_CALIB    = 4'd0;
  localparam logic [3:0] ST_INIT_ACK = 4'd1;
  localparam logic [3:0] ST_IDLE     = 4'd2;
  localparam logic [3:0] ST_WD0      = 4'd3;
  localparam logic [3:0] ST_WD1      = 4'd4;
  localparam logic [3:0] ST_WC0      = 4'd5;
  localparam logic [3:0] ST_WC1      = 4'd6;
  localparam logic [3:0] ST_RC0      = 4'd7;
  localparam logic [3:0] ST_RC1      = 4'd8;
  localparam logic [3:0] ST_RWAIT    = 4'd9;
  localparam logic [3:0] ST_ACK      = 4'd10;

  // x16 column address of one 16-byte half of a 32-byte line.
  function automatic logic [27:0] burst_addr(input logic [LINE_IDX_W-1:0] line, input logic beat);
    return {line, beat, 3'b000};
  endfunction

endpackage

// File: rtl/ddr3_line_asm.sv
// Read-line assembly: counts returned MIG beats and stores them in order into a
// 256-bit register; can be cleared, and can pad missing halves with all-ones.
module ddr3_line_asm
  import ddr3_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clr,
  input  logic              i_cap_en,
  input  logic              i_rd_valid,
  input  logic [BEAT_W-1:0] i_rd_data,
  input  logic              i_fill,
  output logic [LINE_W-1:0] o_line,
  output logic [1:0]        o_cnt
);

  logic [LINE_W-1:0] r_line;
  logic [1:0]        r_cnt;

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_line <= '0;
      r_cnt  <= 2'd0;
    end else if (i_fill) begin
      if (r_cnt == 2'd0) r_line <= '1;
      else               r_line[LINE_W-1:BEAT_W] <= '1;
      r_cnt <= 2'd2;
    end else if (i_cap_en && i_rd_valid && (r_cnt != 2'd2)) begin
      if (r_cnt == 2'd0) r_line[BEAT_W-1:0]      <= i_rd_data;
      else               r_line[LINE_W-1:BEAT_W] <= i_rd_data;
      r_cnt <= r_cnt + 2'd1;
    end
  end

  assign o_line = r_line;
  assign o_cnt  = r_cnt;

endmodule

// File: rtl/ddr3_line_ctrl.sv
// Cache-line to MIG app-interface adapter: one 256-bit request becomes two 128-bit
// bursts. Optional read watchdog enabled by defining DDR3_LINE_CTRL_TIMEOUT_EN.
module ddr3_line_ctrl
  import ddr3_pkg::*;
#(
  parameter int APP_ADDR_W     = 28,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [28:0]           ctrl_addr_i,
  input  logic [LINE_W-1:0]     ctrl_data_i,
  output logic [LINE_W-1:0]     ctrl_data_o,
  input  logic                  ctrl_we_i,
  input  logic                  ctrl_rd_i,
  output logic                  ctrl_ack_o,
  input  logic                  init_calib_complete,
  output logic [APP_ADDR_W-1:0] app_addr,
  output logic [2:0]            app_cmd,
  output logic                  app_en,
  input  logic                  app_rdy,
  output logic [BEAT_W-1:0]     app_wdf_data,
  output logic                  app_wdf_wren,
  output logic                  app_wdf_end,
  input  logic                  app_wdf_rdy,
  output logic [15:0]           app_wdf_mask,
  input  logic [BEAT_W-1:0]     app_rd_data,
  input  logic                  app_rd_data_valid,
  output logic                  err_o
);

  logic [3:0]            r_state;
  logic [3:0]            w_state_nxt;
  logic [LINE_IDX_W-1:0] r_line;
  logic [1:0]            w_beat_cnt;
  logic                  w_fill;
  logic                  w_accept_wr;
  logic                  w_accept_rd;
  logic                  w_cap_en;
  logic                  w_beat_sel;
  logic                  w_unused_addr;

  assign w_accept_wr   = (r_state == ST_IDLE) && ctrl_we_i;
  assign w_accept_rd   = (r_state == ST_IDLE) && !ctrl_we_i && ctrl_rd_i;
  assign w_cap_en      = (r_state == ST_RC1) || (r_state == ST_RWAIT);
  assign w_unused_addr = ^ctrl_addr_i[4:0];

`ifdef DDR3_LINE_CTRL_TIMEOUT_EN
  logic [15:0] r_to_cnt;
  logic        r_err;

  // Watchdog only fires in RWAIT, so a command still waiting on app_rdy is never abandoned.
  assign w_fill = (r_state == ST_RWAIT) && (w_beat_cnt != 2'd2) &&
                  (r_to_cnt >= 16'(TIMEOUT_CYCLES));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_to_cnt <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_accept_rd)
        r_to_cnt <= '0;
      else if (w_cap_en && (r_to_cnt != 16'hFFFF))
        r_to_cnt <= r_to_cnt + 16'd1;
      if (w_fill) r_err <= 1'b1;
    end
  end

  assign err_o = r_err;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
  assign w_fill           = 1'b0;
  assign err_o            = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_CALIB;
      r_line  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept_wr || w_accept_rd) r_line <= ctrl_addr_i[28:5];
    end
  end

  // NOTE: next state defaults to the current state before the case, so no path
  // through this block leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_CALIB:    if (init_calib_complete) w_state_nxt = ST_INIT_ACK;
      ST_INIT_ACK: w_state_nxt = ST_IDLE;
      ST_IDLE: begin
        if (ctrl_we_i)      w_state_nxt = ST_WD0;
        else if (ctrl_rd_i) w_state_nxt = ST_RC0;
      end
      ST_WD0:   if (app_wdf_rdy) w_state_nxt = ST_WD1;
      ST_WD1:   if (app_wdf_rdy) w_state_nxt = ST_WC0;
      ST_WC0:   if (app_rdy)     w_state_nxt = ST_WC1;
      ST_WC1:   if (app_rdy)     w_state_nxt = ST_ACK;
      ST_RC0:   if (app_rdy)     w_state_nxt = ST_RC1;
      ST_RC1:   if (app_rdy)     w_state_nxt = ST_RWAIT;
      ST_RWAIT: if ((w_beat_cnt == 2'd2) || w_fill) w_state_nxt = ST_ACK;
      ST_ACK:   w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_CALIB;
    endcase
  end

  ddr3_line_asm u_asm (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (w_accept_rd),
    .i_cap_en   (w_cap_en),
    .i_rd_valid (app_rd_data_valid),
    .i_rd_data  (app_rd_data),
    .i_fill     (w_fill),
    .o_line     (ctrl_data_o),
    .o_cnt      (w_beat_cnt)
  );

  // MIG-facing outputs are pure decodes of state and latched line, never of MIG inputs.
  assign w_beat_sel   = (r_state == ST_WC1) || (r_state == ST_RC1);
  assign app_en       = (r_state == ST_WC0) || (r_state == ST_WC1) ||
                        (r_state == ST_RC0) || (r_state == ST_RC1);
  assign app_cmd      = ((r_state == ST_RC0) || (r_state == ST_RC1)) ? APP_CMD_RD : APP_CMD_WR;
  assign app_addr     = APP_ADDR_W'(burst_addr(r_line, w_beat_sel));
  assign app_wdf_wren = (r_state == ST_WD0) || (r_state == ST_WD1);
  assign app_wdf_end  = app_wdf_wren;
  assign app_wdf_data = (r_state == ST_WD1) ? ctrl_data_i[LINE_W-1:BEAT_W]
                                            : ctrl_data_i[BEAT_W-1:0];
  assign app_wdf_mask = 16'h0000;
  assign ctrl_ack_o   = (r_state == ST_INIT_ACK) || (r_state == ST_ACK);

endmodule
